// File: rtl/systolic_act_feeder.sv
// Activation feeder for a weight-stationary systolic array: vector FIFO, diagonal skew, run control FSM.
// Optional underrun counter built when ACT_FEEDER_UNDERRUN_CNT_EN is defined.
module systolic_act_feeder #(
  parameter int WORD_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_WIDTH*ROWS-1:0] in_data,
  input  logic                       in_last,
  input  logic                       start,
  output logic [1:0]                 control,
  output logic [WORD_WIDTH*ROWS-1:0] a_out,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                underrun_cnt
);

  localparam int VW        = WORD_WIDTH * ROWS;
  localparam int AW        = $clog2(DEPTH);
  localparam int DRAIN_LEN = ROWS + COLS - 1;
  localparam int DW        = $clog2(DRAIN_LEN + 1);

  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic [VW:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push, pop, fifo_empty;
  logic [VW-1:0]   inj;
  logic            exit_run;
  logic [DW-1:0]   drain_cnt;

  assign in_ready   = (count < FULL_CNT);
  assign fifo_empty = (count == '0);
  assign push       = in_valid && in_ready;
  assign busy       = (state != IDLE);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    inj        = '0;
    exit_run   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = STREAM;
      end
      STREAM: begin
        // An empty FIFO injects a zero bubble rather than stalling the array.
        if (!fifo_empty) begin
          pop = 1'b1;
          inj = mem[rd_ptr][VW-1:0];
          if (mem[rd_ptr][VW]) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_next = IDLE;
          exit_run   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  always_ff @(posedge clk) begin
    if (reset || state != DRAIN) drain_cnt <= '0;
    else                         drain_cnt <= drain_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      control <= 2'b00;
      done    <= 1'b0;
    end else begin
      control <= (state_next != IDLE) ? 2'b10 : 2'b00;
      done    <= exit_run;
    end
  end

  // Lane r carries r+1 register stages so row r sees the vector r cycles late.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    localparam int unsigned LEN = r + 1;
    logic [WORD_WIDTH-1:0] pipe [LEN];

    always_ff @(posedge clk) begin
      if (reset || exit_run) begin
        for (int unsigned s = 0; s < LEN; s++) pipe[s] <= '0;
      end else begin
        pipe[0] <= inj[r*WORD_WIDTH +: WORD_WIDTH];
        for (int unsigned s = 1; s < LEN; s++) pipe[s] <= pipe[s-1];
      end
    end

    assign a_out[r*WORD_WIDTH +: WORD_WIDTH] = pipe[LEN-1];
  end

`ifdef ACT_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] underrun_q;

  always_ff @(posedge clk) begin
    if (reset)                                      underrun_q <= '0;
    else if (state == IDLE && start)                underrun_q <= '0;
    else if (state == STREAM && fifo_empty && underrun_q != '1)
                                                    underrun_q <= underrun_q + 1'b1;
  end

  assign underrun_cnt = underrun_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_systolic_act_feeder.sv
// Directed bench for systolic_act_feeder (ROWS=4, COLS=4, DEPTH=8, WORD_WIDTH=8).
module tb_systolic_act_feeder;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_last, start;
  logic        in_ready, busy, done;
  logic [31:0] in_data, a_out;
  logic [1:0]  control;
  logic [15:0] underrun_cnt;

  int n_cmp = 0;
  int n_err = 0;

`ifdef ACT_FEEDER_UNDERRUN_CNT_EN
  localparam int UND_T4 = 3;
  localparam int UND_T6 = 1;
`else
  localparam int UND_T4 = 0;
  localparam int UND_T6 = 0;
`endif

  systolic_act_feeder #(
    .WORD_WIDTH(8),
    .ROWS      (4),
    .COLS      (4),
    .DEPTH     (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .start       (start),
    .control     (control),
    .a_out       (a_out),
    .busy        (busy),
    .done        (done),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] ao [20];
  logic [1:0]  ct [20];
  logic        dn [20];
  logic        ir [20];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] vec(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [7:0] lane(input logic [31:0] v, input int r);
    return v[r*8 +: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input int e);
    step();
    ao[e] = a_out;
    ct[e] = control;
    dn[e] = done;
    ir[e] = in_ready;
  endtask

  task automatic start_run();
    for (int i = 0; i < 20; i++) begin
      ao[i] = 'x; ct[i] = 'x; dn[i] = 1'b0; ir[i] = 'x;
    end
    start = 1'b1;
    cap(0);
    start = 1'b0;
  endtask

  task automatic push_vec(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic stats(input int last_e, output int first_done, output int n_done, output int n_ctl);
    first_done = -1;
    n_done     = 0;
    n_ctl      = 0;
    for (int e = 0; e <= last_e; e++) begin
      if (dn[e]) begin
        n_done++;
        if (first_done < 0) first_done = e;
      end
      if (ct[e] == 2'b10) n_ctl++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int fd, nd, nc;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; start = 1'b0; in_data = '0;
    do_reset();
    check("rst_control", control, 2'b00);
    check("rst_aout", a_out, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_underrun", underrun_cnt, 16'h0);

    // Two preloaded vectors, skew and run timing
    push_vec(vec(1, 2, 3, 4), 1'b0);
    push_vec(vec(5, 6, 7, 8), 1'b1);
    start_run();
    check("t2_busy", busy, 1'b1);
    for (int e = 1; e < 14; e++) cap(e);
    check("t2_l0_e1", lane(ao[1], 0), 8'd1);
    check("t2_l0_e2", lane(ao[2], 0), 8'd5);
    check("t2_l0_e3", lane(ao[3], 0), 8'd0);
    check("t2_l1_e2", lane(ao[2], 1), 8'd2);
    check("t2_l1_e3", lane(ao[3], 1), 8'd6);
    check("t2_l3_e3", lane(ao[3], 3), 8'd0);
    check("t2_l3_e4", lane(ao[4], 3), 8'd4);
    check("t2_l3_e5", lane(ao[5], 3), 8'd8);
    stats(13, fd, nd, nc);
    check("t2_done_edge", fd, 9);
    check("t2_done_cnt", nd, 1);
    check("t2_ctl_cycles", nc, 9);
    check("t2_ctl_e9", ct[9], 2'b00);
    check("t2_aout_e9", ao[9], 32'h0);
    check("t2_busy_end", busy, 1'b0);

    // Underrun: start with empty FIFO, vector arrives three cycles late
    start_run();
    for (int e = 1; e < 3; e++) cap(e);
    in_valid = 1'b1; in_data = vec(9, 10, 11, 12); in_last = 1'b1;
    cap(3);
    in_valid = 1'b0; in_last = 1'b0;
    for (int e = 4; e < 15; e++) cap(e);
    for (int e = 1; e < 4; e++) check($sformatf("t4_bubble_e%0d", e), ao[e], 32'h0);
    check("t4_l0_e4", lane(ao[4], 0), 8'd9);
    check("t4_l3_e7", lane(ao[7], 3), 8'd12);
    stats(14, fd, nd, nc);
    check("t4_done_edge", fd, 11);
    check("t4_underrun", underrun_cnt, UND_T4);

    // start during STREAM and DRAIN is ignored
    push_vec(vec(1, 2, 3, 4), 1'b0);
    push_vec(vec(5, 6, 7, 8), 1'b1);
    start_run();
    start = 1'b1;
    for (int e = 1; e < 9; e++) cap(e);
    start = 1'b0;
    for (int e = 9; e < 15; e++) cap(e);
    stats(14, fd, nd, nc);
    check("t5_done_edge", fd, 9);
    check("t5_done_cnt", nd, 1);
    check("t5_ctl_cycles", nc, 9);
    check("t5_busy_end", busy, 1'b0);
    check("t5_underrun_clr", underrun_cnt, 16'h0);

    // Fill to DEPTH, refused 9th push, in_ready recovery
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'(i);
      push_vec(vec(8'd16 + b, 8'd32 + b, 8'd48 + b, 8'd64 + b), i == 7);
    end
    check("t3_full_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_data = vec(99, 99, 99, 99); in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    check("t3_still_full", in_ready, 1'b0);
    start_run();
    for (int e = 1; e < 19; e++) cap(e);
    check("t3_ready_e0", ir[0], 1'b0);
    check("t3_ready_e1", ir[1], 1'b1);
    for (int e = 1; e < 9; e++) check($sformatf("t3_l0_e%0d", e), lane(ao[e], 0), 32'(15 + e));
    stats(18, fd, nd, nc);
    check("t3_done_edge", fd, 15);
    push_vec(vec(77, 78, 79, 80), 1'b1);
    start_run();
    for (int e = 1; e < 11; e++) cap(e);
    check("t3_no_9th", lane(ao[1], 0), 8'd77);
    stats(10, fd, nd, nc);
    check("t3b_done_edge", fd, 8);

    // Ten pushes during a run, last at index 3 then index 9
    start_run();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'(i);
      in_data = vec(8'd100 + b, 8'd0, 8'd0, 8'd0);
      in_last = (i == 3 || i == 9);
      cap(i + 1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    for (int e = 11; e < 17; e++) cap(e);
    check("t6_l0_e1", ao[1], 32'h0);
    for (int e = 2; e < 6; e++) check($sformatf("t6_l0_e%0d", e), lane(ao[e], 0), 32'(98 + e));
    check("t6_drain_nopop", lane(ao[6], 0), 8'd0);
    stats(16, fd, nd, nc);
    check("t6_done_edge", fd, 12);
    check("t6_underrun", underrun_cnt, UND_T6);
    start_run();
    for (int e = 1; e < 16; e++) cap(e);
    for (int e = 1; e < 7; e++) check($sformatf("t6b_l0_e%0d", e), lane(ao[e], 0), 32'(103 + e));
    stats(15, fd, nd, nc);
    check("t6b_done_edge", fd, 13);

    // Reset while in DRAIN
    push_vec(vec(1, 2, 3, 4), 1'b1);
    push_vec(vec(200, 201, 202, 203), 1'b0);
    start_run();
    for (int e = 1; e < 4; e++) cap(e);
    check("t1_pre_busy", busy, 1'b1);
    check("t1_pre_ctl", control, 2'b10);
    do_reset();
    check("t1_control", control, 2'b00);
    check("t1_aout", a_out, 32'h0);
    check("t1_busy", busy, 1'b0);
    check("t1_in_ready", in_ready, 1'b1);
    check("t1_done", done, 1'b0);
    start_run();
    cap(1);
    check("t1_fifo_empty", ao[1], 32'h0);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
